// File: rtl/dsp_sched_pkg.sv
// rtl/dsp_sched_pkg.sv - shared widths, FSM states and tag type for dsp_sched
package dsp_sched_pkg;
    localparam int A_W   = 18;
    localparam int C_W   = 48;
    localparam int P_W   = 48;
    localparam int N_MAX = 8;
    localparam int ID_W  = $clog2(N_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/dsp_sched_rr_arbiter.sv
// rtl/dsp_sched_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);
    logic found;
    int   j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/dsp_sched.sv
// rtl/dsp_sched.sv - round-robin sharing of one pipelined DSP slice among N_REQ requesters
module dsp_sched
    import dsp_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DSP_LAT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*A_W-1:0]         req_a,
    input  logic [N_REQ*A_W-1:0]         req_b,
    input  logic [N_REQ*A_W-1:0]         req_d,
    input  logic [N_REQ*C_W-1:0]         req_c,
    output logic [A_W-1:0]               dsp_a,
    output logic [A_W-1:0]               dsp_b,
    output logic [A_W-1:0]               dsp_d,
    output logic [C_W-1:0]               dsp_c,
    output logic                         dsp_ce,
    input  logic [P_W-1:0]               dsp_p,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [P_W-1:0]               rsp_p,
    output logic [$clog2(DSP_LAT+3)-1:0] inflight,
    output logic                         busy
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(DSP_LAT+3);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             hs;
    logic             rsp_any;
    tag_t             pipe [DSP_LAT+1];

    rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign req_ready = (en && state == RUN) ? arb_grant : '0;
    assign hs        = |req_ready;
    assign rsp_any   = |rsp_valid;
    assign busy      = (state != IDLE) || (inflight != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = (inflight != '0) ? DRAIN : IDLE;
            DRAIN:   if (en) state_nxt = RUN;
                     else if (inflight == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            dsp_a    <= '0;
            dsp_b    <= '0;
            dsp_d    <= '0;
            dsp_c    <= '0;
            dsp_ce   <= 1'b0;
            inflight <= '0;
        end else begin
            state  <= state_nxt;
            dsp_ce <= hs;
            if (hs) begin
                ptr   <= (arb_idx == IDX_W'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
                dsp_a <= req_a[arb_idx*A_W +: A_W];
                dsp_b <= req_b[arb_idx*A_W +: A_W];
                dsp_d <= req_d[arb_idx*A_W +: A_W];
                dsp_c <= req_c[arb_idx*C_W +: C_W];
            end
            // Simultaneous issue and retire leave the count unchanged.
            if (hs && !rsp_any && inflight != CNT_W'(DSP_LAT+2))
                inflight <= inflight + 1'b1;
            else if (!hs && rsp_any && inflight != '0)
                inflight <= inflight - 1'b1;
        end
    end

    // Tag pipe: stage DSP_LAT lines up with the slice result of that issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= DSP_LAT; s++) pipe[s] <= '0;
            rsp_valid <= '0;
            rsp_p     <= '0;
        end else begin
            pipe[0].vld <= hs;
            pipe[0].id  <= ID_W'(arb_idx);
            for (int s = 1; s <= DSP_LAT; s++) pipe[s] <= pipe[s-1];
            if (pipe[DSP_LAT].vld) begin
                rsp_valid <= N_REQ'(1) << pipe[DSP_LAT].id;
                rsp_p     <= dsp_p;
            end else begin
                rsp_valid <= '0;
            end
        end
    end
endmodule

// File: doc/dsp_sched.md
# dsp_sched

Round-robin scheduler that shares one pipelined DSP slice (P = (D+A)*B + C, 18-bit A/B/D, 48-bit C/P) between N_REQ requesters. It accepts at most one operand set per cycle via valid/ready and drives the slice's operand ports. It tracks each in-flight operation through the slice's fixed latency and returns the result to the issuing requester as a one-cycle pulse. It sits between the filter/accumulator clients and the single DSP instance in the datapath.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- DSP_LAT, 4: cycles from operands being valid on dsp_* to the result on dsp_p.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scheduler enable; low stops new grants, in-flight work drains.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_a, req_b, req_d  in  N_REQ*18  packed operands, requester i at bits [18i+17:18i].
- req_c  in  N_REQ*48  packed C operands.
- dsp_a, dsp_b, dsp_d  out  18  registered operands to the slice.
- dsp_c  out  48  registered C operand.
- dsp_ce  out  1  operands on dsp_* are a new issue this cycle.
- dsp_p  in  48  slice result.
- rsp_valid  out  N_REQ  one-hot result pulse to the owning requester.
- rsp_p  out  48  result, valid while any rsp_valid bit is high.
- inflight  out  $clog2(DSP_LAT+3)  outstanding operations.
- busy  out  1  high when state is not IDLE or inflight is non-zero.

## Operation
- Handshake: requester i transfers when req_valid[i] and req_ready[i] are both high. req_ready is combinational from req_valid, en, state and the pointer. Requesters must not make valid depend on ready.
- Arbitration: search req_valid starting at the pointer, ascending with wrap. The first set bit gets ready, but only if en is high and state is RUN.
  - The pointer becomes (granted index + 1) mod N_REQ on each handshake.
  - The pointer is unchanged on cycles with no handshake.
- Issue: on a handshake, the granted operands are registered onto dsp_a/b/c/d and dsp_ce is 1 in the next cycle. On cycles with no handshake, dsp_ce is 0 and dsp_* hold their previous values.
- Tag pipe: a shift register of DSP_LAT+1 stages, each stage {vld, id}, tracks each issue to its result. When the last stage is valid, dsp_p is registered to rsp_p and rsp_valid[id] pulses for one cycle.
- No response backpressure: requesters must accept a rsp_valid pulse unconditionally.
- inflight counter: +1 on handshake, −1 on a rsp_valid pulse, unchanged when both occur in the same cycle. Its maximum is DSP_LAT+2 and it never wraps.
- FSM, states IDLE, RUN, DRAIN:
  - IDLE → RUN when en=1.
  - RUN → DRAIN when en=0 and inflight>0.
  - RUN → IDLE when en=0 and inflight=0.
  - DRAIN → RUN when en=1.
  - DRAIN → IDLE when inflight reaches 0.
- Dropping en in mid-stream blocks new grants from the same cycle. Results already issued are still delivered.

## Timing
- Reset values: all outputs 0, pointer 0, tag pipe cleared, state IDLE.
- Reset mid-operation discards every in-flight tag. No rsp_valid follows for work accepted before reset.
- Latency: a handshake in cycle T gives dsp_ce=1 in T+1 and rsp_valid in T+2+DSP_LAT.
- Throughput: one issue and one response per cycle sustained.
- A handshake, a response and an en change can all occur in the same cycle; each follows its own rule above independently.

## Structure
- Package dsp_sched_pkg holds:
  - A_W=18, C_W=48, P_W=48.
  - state enum {IDLE, RUN, DRAIN}.
  - tag_t struct {vld, id[$clog2(N_MAX)-1:0]}, with N_MAX=8.
- Sub-module rr_arbiter(N): inputs req and pointer, outputs a one-hot grant and a grant index. It is purely combinational. The pointer register lives in dsp_sched.

## Test plan
All scenarios use N_REQ=4 and DSP_LAT=4, with the slice modelled as P=(D+A)*B+C.
1. Reset: rst=1 for 3 cycles with req_valid=0 → every output 0. After release with en=0 and req_valid=1111 → req_ready stays 0 and busy=0.
2. Single op: en=1, req 2 with A=3, D=2, B=4, C=10, handshake at cycle 0 → dsp_ce=1 at cycle 1; rsp_valid=0100 and rsp_p=30 at cycle 6; inflight returns to 0.
3. Saturation: all four requesters valid for 8 cycles → grants 0,1,2,3,0,1,2,3; responses arrive in the same order, one per cycle, from cycle 6; inflight peaks at 6.
4. Sparse fairness: only req 1 and req 3 valid → grants alternate 1,3,1,3. The pointer does not move on idle cycles.
5. Enable drop: en falls after 3 grants → req_ready is 0 that cycle and state is DRAIN. busy stays 1 until the third rsp_valid, then the state is IDLE. Raising en again grants, starting from the pointer.
6. Reset mid-flight: 3 ops outstanding, then rst pulses → no rsp_valid for 10 cycles, inflight=0, and the next grant goes to requester 0.
